// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state type and sizing helpers for the shift-add multiplier controller
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } mult_state_t;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/step_counter.sv
// rtl/step_counter.sv - load-zero / increment counter with a terminal-value flag
module step_counter #(
  parameter int           W    = 3,
  parameter logic [W-1:0] TERM = '1
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == TERM);

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// rtl/shift_add_mult_ctrl.sv - step-counted shift-add multiplier sequencer with signed mode
// Define MULT_CTRL_OP_COUNT_EN to add the Op_Count output (number of Add/Sub cycles).
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic Signed_Mode,
  input  logic M,
  output logic Clr_Ld,
  output logic Shift,
  output logic Add,
  output logic Sub,
  output logic ClearA,
  output logic Busy,
  output logic Done
`ifdef MULT_CTRL_OP_COUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] Op_Count
`endif
);

  localparam int            CW        = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  mult_state_t   state_q, state_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] step_cnt;
  logic          last;
  logic          start;
  logic          step_inc;

  assign start    = (state_q == IDLE) && Run;
  // The counter stops at the last step so it never wraps into a second pass.
  assign step_inc = !last && (((state_q == EVAL) && !M) || (state_q == SHIFT));
  assign mode_d   = start ? Signed_Mode : mode_q;

  step_counter #(
    .W    (CW),
    .TERM (LAST_STEP)
  ) u_step (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clr_i   (start),
    .inc_i   (step_inc),
    .cnt_o   (step_cnt),
    .last_o  (last)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Run) state_d = EVAL;
      EVAL: begin
        if (M)         state_d = SHIFT;
        else if (last) state_d = HOLD;
      end
      SHIFT:   state_d = last ? HOLD : EVAL;
      HOLD:    if (!Run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Held reset keeps A and X cleared so the datapath never sees a stale strobe.
  always_comb begin
    Clr_Ld = 1'b0;
    Shift  = 1'b0;
    Add    = 1'b0;
    Sub    = 1'b0;
    ClearA = 1'b0;
    Busy   = 1'b0;
    Done   = 1'b0;
    if (!Reset_n) begin
      ClearA = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (Run) begin
            ClearA = 1'b1;
          end else begin
            Clr_Ld = ClearA_LoadB;
            ClearA = ClearA_LoadB;
          end
        end
        EVAL: begin
          Busy = 1'b1;
          if (M) begin
            if (last && mode_q) Sub = 1'b1;
            else                Add = 1'b1;
          end else begin
            Shift = 1'b1;
          end
        end
        SHIFT: begin
          Busy  = 1'b1;
          Shift = 1'b1;
        end
        HOLD:    Done = 1'b1;
        default: ;
      endcase
    end
  end

  step_cnt_bound: assert property (@(posedge Clk) disable iff (!Reset_n) step_cnt <= LAST_STEP);

`ifdef MULT_CTRL_OP_COUNT_EN
  logic op_last;

  step_counter #(
    .W    ($clog2(WIDTH+1)),
    .TERM ($clog2(WIDTH+1)'(WIDTH))
  ) u_ops (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clr_i   (start),
    .inc_i   ((Add | Sub) && !op_last),
    .cnt_o   (Op_Count),
    .last_o  (op_last)
  );
`endif

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb/tb_shift_add_mult_ctrl.sv - scoreboard bench for the shift-add multiplier controller
module tb_shift_add_mult_ctrl;

  localparam logic [2:0] C_SHIFT = 3'b100;
  localparam logic [2:0] C_ADD   = 3'b010;
  localparam logic [2:0] C_SUB   = 3'b001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, calb, sgn, run8, run16;
  logic [7:0]  b8, sw8;
  logic [15:0] b16, sw16;
  logic s8_clrld, s8_shift, s8_add, s8_sub, s8_cleara, s8_busy, s8_done;
  logic s16_clrld, s16_shift, s16_add, s16_sub, s16_cleara, s16_busy, s16_done;
`ifdef MULT_CTRL_OP_COUNT_EN
  logic [3:0] op8;
  logic [4:0] op16;
`endif

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_code [2][$];
  int         exp_lat  [2][$];
`ifdef MULT_CTRL_OP_COUNT_EN
  int         exp_ops  [2][$];
`endif
  int   busy_cnt  [2];
  logic done_prev [2];

  shift_add_mult_ctrl #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Reset_n(rst_n), .Run(run8), .ClearA_LoadB(calb), .Signed_Mode(sgn), .M(b8[0]),
    .Clr_Ld(s8_clrld), .Shift(s8_shift), .Add(s8_add), .Sub(s8_sub), .ClearA(s8_cleara),
    .Busy(s8_busy), .Done(s8_done)
`ifdef MULT_CTRL_OP_COUNT_EN
    , .Op_Count(op8)
`endif
  );

  shift_add_mult_ctrl #(.WIDTH(16)) u_dut16 (
    .Clk(clk), .Reset_n(rst_n), .Run(run16), .ClearA_LoadB(calb), .Signed_Mode(sgn), .M(b16[0]),
    .Clr_Ld(s16_clrld), .Shift(s16_shift), .Add(s16_add), .Sub(s16_sub), .ClearA(s16_cleara),
    .Busy(s16_busy), .Done(s16_done)
`ifdef MULT_CTRL_OP_COUNT_EN
    , .Op_Count(op16)
`endif
  );

  // B registers: load from switches on Clr_Ld, arithmetic right shift on Shift
  always @(posedge clk) begin
    if (s8_clrld)      b8 <= sw8;
    else if (s8_shift) b8 <= {b8[7], b8[7:1]};
    if (s16_clrld)      b16 <= sw16;
    else if (s16_shift) b16 <= {b16[15], b16[15:1]};
  end

  task automatic note_fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    bad++;
    $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) note_fail(name, act, exp);
  endtask

  // bits: [6]Clr_Ld [5]Shift [4]Add [3]Sub [2]ClearA [1]Busy [0]Done
  function automatic logic [6:0] outs(input int idx);
    if (idx == 0) return {s8_clrld, s8_shift, s8_add, s8_sub, s8_cleara, s8_busy, s8_done};
    return {s16_clrld, s16_shift, s16_add, s16_sub, s16_cleara, s16_busy, s16_done};
  endfunction

  task automatic mon(input int idx, input logic [6:0] o
`ifdef MULT_CTRL_OP_COUNT_EN
                     , input int opc
`endif
                    );
    logic [2:0] e;
    int l;
    if (o[1]) begin
      busy_cnt[idx]++;
      if (exp_code[idx].size() == 0) begin
        total++;
        note_fail("unexpected_iteration", {29'd0, o[5:3]}, 0);
      end else begin
        e = exp_code[idx].pop_front();
        chk("iter_strobe", {29'd0, o[5:3]}, {29'd0, e});
      end
      chk("iter_side_strobes", {29'd0, o[6], o[2], o[0]}, 0);
    end
    if (o[0] && !done_prev[idx]) begin
      if (exp_lat[idx].size() == 0) begin
        total++;
        note_fail("unexpected_done", 1, 0);
      end else begin
        l = exp_lat[idx].pop_front();
        chk("latency", busy_cnt[idx], l);
`ifdef MULT_CTRL_OP_COUNT_EN
        l = exp_ops[idx].pop_front();
        chk("op_count", opc, l);
`endif
      end
    end
    if (!o[1] && !o[0]) busy_cnt[idx] = 0;
    done_prev[idx] = o[0];
  endtask

  always @(negedge clk) mon(0, outs(0)
`ifdef MULT_CTRL_OP_COUNT_EN
                            , int'(op8)
`endif
                           );
  always @(negedge clk) mon(1, outs(1)
`ifdef MULT_CTRL_OP_COUNT_EN
                            , int'(op16)
`endif
                           );

  task automatic run_op(input int idx, input logic [15:0] b, input logic s, input logic toggle,
                        input logic calb_start, input int lat, input int ops, input int hold);
    int w;
    logic got;
    logic [6:0] o;
    w = (idx == 0) ? 8 : 16;
    if (idx == 0) sw8 = b[7:0];
    else          sw16 = b;
    @(posedge clk); #1 calb = 1'b1;
    @(negedge clk); chk("idle_load", {25'd0, outs(idx)}, 32'b1000100);
    @(posedge clk); #1 calb = calb_start;
    for (int j = 0; j < w; j++) begin
      if (b[j]) begin
        exp_code[idx].push_back((j == w - 1 && s) ? C_SUB : C_ADD);
        exp_code[idx].push_back(C_SHIFT);
      end else begin
        exp_code[idx].push_back(C_SHIFT);
      end
    end
    exp_lat[idx].push_back(lat);
`ifdef MULT_CTRL_OP_COUNT_EN
    exp_ops[idx].push_back(ops);
`else
    if (ops < 0) $display("negative op count requested");
`endif
    sgn = s;
    if (idx == 0) run8 = 1'b1;
    else          run16 = 1'b1;
    @(negedge clk); chk("start_cycle", {25'd0, outs(idx)}, 32'b0000100);
    @(posedge clk); #1;
    calb = toggle;
    if (toggle) sgn = ~s;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      o = outs(idx);
      if (o[0]) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'd0, got}, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); chk("hold_with_run_high", {25'd0, outs(idx)}, 32'b0000001);
    end
    @(posedge clk); #1;
    run8 = 1'b0; run16 = 1'b0; calb = 1'b0; sgn = 1'b0;
    @(negedge clk); chk("hold_until_edge", {25'd0, outs(idx)}, 32'b0000001);
    @(negedge clk); chk("back_to_idle", {25'd0, outs(idx)}, 0);
    chk("iter_queue_drained", exp_code[idx].size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; calb = 1'b0; sgn = 1'b0; run8 = 1'b0; run16 = 1'b0;
    sw8 = 8'h00; sw16 = 16'h0000;
    done_prev[0] = 1'b0; done_prev[1] = 1'b0;
    busy_cnt[0] = 0; busy_cnt[1] = 0;
    repeat (2) @(negedge clk);
    chk("reset_out8", {25'd0, outs(0)}, 32'b0000100);
    chk("reset_out16", {25'd0, outs(1)}, 32'b0000100);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_out8", {25'd0, outs(0)}, 0);
    chk("idle_out16", {25'd0, outs(1)}, 0);

    run_op(0, 16'h0000, 1'b0, 1'b0, 1'b0, 8, 0, 3);
    run_op(0, 16'h0081, 1'b1, 1'b1, 1'b0, 10, 2, 1);
    run_op(0, 16'h0081, 1'b0, 1'b1, 1'b1, 10, 2, 1);
    run_op(1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 32, 16, 2);

    // abort an 8-bit run during step 3
    sw8 = 8'h00;
    @(posedge clk); #1 calb = 1'b1;
    @(posedge clk); #1 calb = 1'b0;
    for (int j = 0; j < 3; j++) exp_code[0].push_back(C_SHIFT);
    run8 = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0; run8 = 1'b0;
    @(negedge clk); chk("reset_mid_run", {25'd0, outs(0)}, 32'b0000100);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("post_reset_idle", {25'd0, outs(0)}, 0);
    chk("abort_queue_drained", exp_code[0].size(), 0);

    run_op(0, 16'h005A, 1'b0, 1'b0, 1'b1, 12, 4, 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
